bcd_addsub_serial: RTL

Digit-serial, parametrised packed-BCD adder/subtractor. It takes two DIGITS-wide unsigned BCD operands and a mode bit, then processes one decimal digit per clock, least significant digit first. It returns a sign-magnitude BCD result with carry, negative and error flags. It succeeds the fixed 3-digit complement subtractor with arbitrary width, both operations, a start/done handshake, input validation and a magnitude-correction pass for negative differences.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adder.sv | 27 ++
 rtl/bcd_addsub_serial.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ADD   = 3'd2,
      FIX   = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_ADJ = 4'd6;

   // True when the nibble is a legal decimal digit.
   function automatic logic is_bcd(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit decimal adder: a + b + cin with decimal correction.
// Both addends are expected to be valid BCD digits, so the raw sum is at most 19.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   output bcd_digit_t digit,
   output logic       cout
);

   logic [4:0] sum;

   // Binary add, then fold sums above 9 back into a decimal digit plus carry.
   always_comb begin
      sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      if (sum > {1'b0, BCD_MAX}) begin
         digit = sum[3:0] + BCD_ADJ;
         cout  = 1'b1;
      end else begin
         digit = sum[3:0];
         cout  = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Handshake: a request is taken on any rising edge where start=1 and ready=1
// (ready is high only in IDLE); start while ready=0 is ignored. done pulses for
// exactly one cycle, and result/carry/neg/err are valid from that cycle and hold
// until the done of the next operation.
module bcd_addsub_serial
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic                ready,
   output logic                done,
   output logic [4*DIGITS-1:0] result,
   output logic                carry,
   output logic                neg,
   output logic                err,
   output state_t              state_dbg
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   state_t         state;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-1:0]   work;
   logic           mode_r;
   logic           c;
   logic [CW-1:0]  cnt;

   logic           operands_ok;
   logic           last_digit;
   bcd_digit_t     add_a;
   bcd_digit_t     add_b;
   bcd_digit_t     add_digit;
   logic           add_cin;
   logic           add_cout;
   logic [W+3:0]   work_cat;
   logic [W+3:0]   a_cat;
   logic [W+3:0]   b_cat;
   logic [W-1:0]   work_next;
   logic [W-1:0]   a_rot;
   logic [W-1:0]   b_rot;

   assign state_dbg  = state;
   assign last_digit = (cnt == CW'(DIGITS - 1));

   // Scan every nibble of the latched operands for non-decimal codes.
   always_comb begin
      operands_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_bcd(a_sh[4*i +: 4]) || !is_bcd(b_sh[4*i +: 4]))
            operands_ok = 1'b0;
      end
   end

   // Adder input mux: operands (B nines-complemented for subtract) in ADD,
   // nines-complement of the working digit in FIX.
   always_comb begin
      add_a   = a_sh[3:0];
      add_b   = mode_r ? (BCD_MAX - b_sh[3:0]) : b_sh[3:0];
      add_cin = c;
      if (state == FIX) begin
         add_a = BCD_MAX - work[3:0];
         add_b = '0;
      end
   end

   bcd_digit_adder u_digit_adder (
      .a     (add_a),
      .b     (add_b),
      .cin   (add_cin),
      .digit (add_digit),
      .cout  (add_cout)
   );

   // Shift/rotate by one digit; written via concatenate-and-shift so DIGITS=1 works.
   always_comb begin
      work_cat  = {add_digit, work} >> 4;
      a_cat     = {a_sh[3:0], a_sh} >> 4;
      b_cat     = {b_sh[3:0], b_sh} >> 4;
      work_next = work_cat[W-1:0];
      a_rot     = a_cat[W-1:0];
      b_rot     = b_cat[W-1:0];
   end

   // Control FSM with the datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         result <= '0;
         carry  <= 1'b0;
         neg    <= 1'b0;
         err    <= 1'b0;
         a_sh   <= '0;
         b_sh   <= '0;
         work   <= '0;
         mode_r <= 1'b0;
         c      <= 1'b0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  mode_r <= mode;
                  ready  <= 1'b0;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               if (!operands_ok) begin
                  result <= '0;
                  carry  <= 1'b0;
                  neg    <= 1'b0;
                  err    <= 1'b1;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt   <= '0;
                  c     <= mode_r;
                  work  <= '0;
                  state <= ADD;
               end
            end
            ADD: begin
               work <= work_next;
               a_sh <= a_rot;
               b_sh <= b_rot;
               c    <= add_cout;
               cnt  <= cnt + CW'(1);
               if (last_digit) begin
                  if (!mode_r || add_cout) begin
                     // Sum, or non-negative difference: the working value is final.
                     result <= work_next;
                     carry  <= !mode_r && add_cout;
                     neg    <= 1'b0;
                     err    <= 1'b0;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     // No end-around carry means A<B: convert to magnitude.
                     c     <= 1'b1;
                     cnt   <= '0;
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               work <= work_next;
               c    <= add_cout;
               cnt  <= cnt + CW'(1);
               if (last_digit) begin
                  result <= work_next;
                  carry  <= 1'b0;
                  neg    <= 1'b1;
                  err    <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
